// File: rtl/seg_display_driver.sv
// Four-digit multiplexed seven-segment driver for a 12-bit unsigned value.
// Binary-to-BCD uses sequential double dabble; digits are scanned on a refresh timer.
module seg_display_driver #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter bit          BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [11:0] value,
    input  logic        load,
    output logic        busy,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int unsigned     CW       = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]   REF_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [3:0]      LAST_IT  = 4'd11;

    typedef enum logic {
        S_IDLE,
        S_CONV
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [27:0]   r_shift;
    logic [3:0]    r_cnt;
    logic [15:0]   r_disp;
    logic [CW-1:0] r_refresh;
    logic [1:0]    r_idx;

    logic [27:0]   w_adj;
    logic [27:0]   w_shifted;
    logic          w_last;
    logic [3:0]    w_digit;
    logic [3:0]    w_lz;
    logic          w_blank;

    assign w_last = (r_state == S_CONV) && (r_cnt == LAST_IT);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (load) w_state_next = S_CONV;
            S_CONV:  if (r_cnt == LAST_IT) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Add-3 correction on the four BCD nibbles sitting above the binary field.
    always_comb begin
        w_adj = r_shift;
        for (int unsigned i = 0; i < 4; i++) begin
            if (r_shift[12 + 4*i +: 4] >= 4'd5) begin
                w_adj[12 + 4*i +: 4] = r_shift[12 + 4*i +: 4] + 4'd3;
            end
        end
        w_shifted = w_adj << 1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_disp  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_shift <= {16'b0, value};
                        r_cnt   <= '0;
                    end
                end
                S_CONV: begin
                    r_shift <= w_shifted;
                    r_cnt   <= r_cnt + 4'd1;
                    if (w_last) begin
                        r_disp <= w_shifted[27:12];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_refresh <= '0;
            r_idx     <= '0;
        end else if (r_refresh == REF_LAST) begin
            r_refresh <= '0;
            r_idx     <= r_idx + 2'd1;
        end else begin
            r_refresh <= r_refresh + 1'b1;
        end
    end

    assign busy = (r_state == S_CONV);

    always_comb begin
        w_digit = 4'd0;
        case (r_idx)
            2'd0: w_digit = r_disp[3:0];
            2'd1: w_digit = r_disp[7:4];
            2'd2: w_digit = r_disp[11:8];
            2'd3: w_digit = r_disp[15:12];
            default: w_digit = 4'd0;
        endcase
    end

    // A digit is a leading zero only if it and every higher digit are zero.
    always_comb begin
        w_lz    = '0;
        w_lz[3] = (r_disp[15:12] == 4'd0);
        w_lz[2] = w_lz[3] && (r_disp[11:8] == 4'd0);
        w_lz[1] = w_lz[2] && (r_disp[7:4] == 4'd0);
        w_lz[0] = 1'b0;
        w_blank = BLANK_LZ && w_lz[r_idx];
    end

    always_comb begin
        seg = 7'b1111111;
        if (!w_blank) begin
            case (w_digit)
                4'd0: seg = 7'b1000000;
                4'd1: seg = 7'b1111001;
                4'd2: seg = 7'b0100100;
                4'd3: seg = 7'b0110000;
                4'd4: seg = 7'b0011001;
                4'd5: seg = 7'b0010010;
                4'd6: seg = 7'b0000010;
                4'd7: seg = 7'b1111000;
                4'd8: seg = 7'b0000000;
                4'd9: seg = 7'b0010000;
                default: seg = 7'b1111111;
            endcase
        end
    end

    assign an = ~(4'b0001 << r_idx);
    assign dp = 1'b1;

endmodule

// File: tb/tb_seg_display_driver.sv
// Self-checking bench: two instances (blanking on/off) share stimulus and are
// compared slot by slot against a decimal reference model.
module tb_seg_display_driver;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        load;
    logic [11:0] value;
    logic        busy_b, busy_f, dp_b, dp_f;
    logic [3:0]  an_b, an_f;
    logic [6:0]  seg_b, seg_f;

    int errors = 0;
    int checks = 0;
    logic [6:0] seg_tab [10];

    always #5 clk = ~clk;

    seg_display_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) u_blank (
        .clk(clk), .reset_n(reset_n), .value(value), .load(load),
        .busy(busy_b), .an(an_b), .seg(seg_b), .dp(dp_b)
    );

    seg_display_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) u_full (
        .clk(clk), .reset_n(reset_n), .value(value), .load(load),
        .busy(busy_f), .an(an_f), .seg(seg_f), .dp(dp_f)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected seg for slots 3..0 packed as slot k at [7k +: 7].
    function automatic logic [27:0] model(input int v, input bit blank);
        int pw [4];
        int d;
        logic [27:0] r;
        pw[0] = 1; pw[1] = 10; pw[2] = 100; pw[3] = 1000;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            d = (v / pw[k]) % 10;
            if (blank && k > 0 && v < pw[k]) r[7*k +: 7] = 7'b1111111;
            else                             r[7*k +: 7] = seg_tab[d];
        end
        return r;
    endfunction

    task automatic capture(output logic [27:0] cb, output logic [27:0] cf, output bit ok);
        logic [3:0] seen;
        logic [3:0] pat;
        seen = '0;
        cb = '0;
        cf = '0;
        for (int i = 0; i < 40 && seen != 4'hF; i++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                pat = ~(4'b0001 << k);
                if (an_b == pat) begin
                    seen[k] = 1'b1;
                    cb[7*k +: 7] = seg_b;
                    cf[7*k +: 7] = seg_f;
                end
            end
        end
        ok = (seen == 4'hF);
    endtask

    task automatic convert(input logic [11:0] v, output bit ok);
        value = v;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!busy_b) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic verify_display(input string tag, input int v);
        logic [27:0] cb, cf;
        bit ok;
        capture(cb, cf, ok);
        check({tag, "_scan"}, 32'(ok), 32'd1);
        check({tag, "_blank"}, 32'(cb), 32'(model(v, 1'b1)));
        check({tag, "_full"}, 32'(cf), 32'(model(v, 1'b0)));
    endtask

    task automatic load_and_verify(input int v);
        bit ok;
        convert(12'(v), ok);
        check("conv_done", 32'(ok), 32'd1);
        verify_display($sformatf("val%0d", v), v);
    endtask

    initial begin
        logic [3:0] exp_an;
        int boundary [10];

        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        boundary = '{0, 9, 10, 99, 100, 999, 1000, 1005, 4094, 4095};

        reset_n = 1'b0;
        load    = 1'b0;
        value   = '0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset state and scan sequence
        check("rst_an", 32'(an_b), 32'hE);
        check("rst_seg_b", 32'(seg_b), 32'h40);
        check("rst_seg_f", 32'(seg_f), 32'h40);
        check("rst_busy", 32'(busy_b), 32'd0);
        check("rst_dp", 32'({dp_b, dp_f}), 32'h3);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            exp_an = ~(4'b0001 << ((k / 4) % 4));
            check("scan_an_b", 32'(an_b), 32'(exp_an));
            check("scan_an_f", 32'(an_f), 32'(exp_an));
            check("scan_seg_b", 32'(seg_b), (((k / 4) % 4) == 0) ? 32'h40 : 32'h7F);
            check("scan_busy", 32'(busy_b), 32'd0);
        end

        // Full-scale conversion with exact busy window
        value = 12'd4095;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int c = 0; c < 12; c++) begin
            check("busy_hi", 32'(busy_b), 32'd1);
            @(negedge clk);
        end
        check("busy_lo", 32'(busy_b), 32'd0);
        verify_display("max", 4095);

        load_and_verify(7);
        load_and_verify(1005);

        // Load during busy must be ignored
        value = 12'd4095;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (c == 5) begin
                value = 12'd12;
                load  = 1'b1;
            end else begin
                load = 1'b0;
            end
            check("busy2_hi", 32'(busy_b), 32'd1);
            @(negedge clk);
        end
        load = 1'b0;
        check("busy2_lo", 32'(busy_b), 32'd0);
        verify_display("ignored", 4095);

        // Reset mid-conversion clears the display
        value = 12'd4095;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_busy_pre", 32'(busy_b), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("abort_busy", 32'(busy_b), 32'd0);
        verify_display("abort", 0);
        load_and_verify(100);

        // Boundaries, then randomized sweep
        foreach (boundary[i]) load_and_verify(boundary[i]);
        for (int n = 0; n < 120; n++) begin
            load_and_verify(int'($urandom_range(0, 4095)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seg_display_driver.md
Name: seg_display_driver

Overview:
- Consumes the 12-bit unsigned ALU result and drives a 4-digit, common-anode, multiplexed seven-segment display with the value in decimal (0..4095).
- Sits between the ALU top level and the board display pins.
- Converts binary to BCD sequentially using shift-and-add-3 (double dabble), one bit per cycle.
- Holds the converted digits in a display register and scans them under a refresh timer.

Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot; the digit index advances every REFRESH_DIV cycles. Legal range is 2 or more.
- BLANK_LZ, 1: when 1, leading zeros in digits 3..1 are blanked. Digit 0 is never blanked.

Ports:
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  synchronous reset, active low.
- value  input  12  unsigned binary value to display.
- load  input  1  request to convert `value`; sampled only in IDLE.
- busy  output  1  high while a conversion is in progress.
- an  output  4  digit anodes, active low, one-hot-low. Bit 0 is the rightmost (ones) digit.
- seg  output  7  segment cathodes, active low, ordered {g,f,e,d,c,b,a}.
- dp  output  1  decimal point, active low; constant 1 (off).

Behaviour:
- Reset:
  - Applies on any rising edge with reset_n=0.
  - Next state: state=IDLE, busy=0, conversion shift register=0, iteration counter=0, display register (4 BCD nibbles)=0, refresh counter=0, digit index=0.
  - Resulting outputs: an=4'b1110, seg=7'b1000000 ("0"), dp=1.
  - With BLANK_LZ=1, digits 3..1 show 7'b1111111.
  - Reset mid-conversion aborts it. The display register is cleared, not updated with partial results.
- State machine: IDLE, CONV.
  - IDLE with load=1 at edge E0: load {16'b0, value} into the 28-bit shift register, clear the iteration counter, go to CONV, busy=1 after E0.
  - CONV, each edge E1..E12: for every BCD nibble ≥5 add 3, then shift the 28-bit register left by 1, then increment the counter.
  - At E12: write the final BCD nibbles to the display register, go to IDLE, busy=0 after E12.
  - Latency: 12 cycles from load sample to display register update.
- load while busy=1 is ignored, with no queuing. The value present at E0 is the one converted; later changes to `value` have no effect.
- The display register changes only at E12 or reset, so the display never shows intermediate BCD.
- Refresh timer:
  - Counter runs 0..REFRESH_DIV-1 continuously, independent of state.
  - On wrap, the digit index advances 0→1→2→3→0.
  - The timer is unaffected by load or conversion.
- Output decode is combinational from the registered digit index and display register, adding no extra latency.
  - an = ~(4'b0001 << idx).
  - seg patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Any nibble >9 decodes to 1111111. This is unreachable by construction but still required.
- Leading-zero blanking (BLANK_LZ=1):
  - Digit k (k=3..1) is blank iff it and all higher digits are 0.
  - Interior zeros are shown, e.g. 1005 shows 1,0,0,5.
  - A blanked digit still drives its an bit low in its slot, with seg=1111111.

Test Plan:
1. Reset, REFRESH_DIV=4, BLANK_LZ=1, hold 20 cycles → an sequence 1110,1101,1011,0111 with each value held 4 cycles. seg=1000000 in slot 0 and 1111111 in slots 1–3. busy=0.
2. load=1 for one cycle with value=4095 → busy=1 for exactly 12 cycles. Display register then reads 4,0,9,5, and slots 3..0 show seg 0011001, 1000000, 0010000, 0010010.
3. value=7, BLANK_LZ=1 → slot 0 shows 1111000 and slots 1–3 show 1111111. Then value=1005 → slots show 1111001, 1000000, 1000000, 0010010.
4. load 4095, then at busy cycle 5 apply load=1 with value=12 → the second load is ignored, the result is 4095, and busy falls exactly 12 cycles after the first load.
5. load 4095, then drive reset_n=0 for one edge at busy cycle 6 → busy=0 and the display register is 0 on the next cycle. A subsequent load of 100 yields digits 0,1,0,0, with slot 3 blanked.
6. BLANK_LZ=0, value=0 → all four slots show 1000000. Sweep value over 0..4095 and check the BCD digits against a reference model; all must match.
